// File: rtl/ahb_mux_pkg.sv
// ---------------------------------------------------------------------------
// ahb_mux_pkg
//   Shared definitions for the AHB slave-to-master mux with watchdog:
//   - AHB HTRANS and HRESP encodings
//   - response-sequencer state encoding (3 bits)
//   - onehot_idx(): decodes a (zero-padded) 16-bit select vector into
//     {valid, index}. valid is set only when exactly one bit is set.
// ---------------------------------------------------------------------------
package ahb_mux_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01
   } hresp_e;

   typedef enum logic [2:0] {
      ST_PASS = 3'd0,
      ST_DEF1 = 3'd1,
      ST_DEF2 = 3'd2,
      ST_TO1  = 3'd3,
      ST_TO2  = 3'd4
   } mux_state_e;

   // Returns {valid, index}; index is the highest set bit, valid means one-hot.
   function automatic logic [4:0] onehot_idx(input logic [15:0] vec);
      logic [4:0] cnt;
      logic [3:0] idx;
      cnt = 5'd0;
      idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         cnt = cnt + {4'd0, vec[i]};
         idx = vec[i] ? 4'(i) : idx;
      end
      return {(cnt == 5'd1), idx};
   endfunction

endpackage

// File: rtl/ahb_s2m_wdog_cnt.sv
// ---------------------------------------------------------------------------
// ahb_s2m_wdog_cnt
//   Per-transfer wait-state watchdog. Counts consecutive cycles in which the
//   routed slave is stalling a live transfer and flags an abort on the
//   TO_CYC-th such cycle. Holds a sticky abort flag and the offending slave.
//   TO_CYC = 0 disables the watchdog entirely (counter held at zero).
// Ports
//   clk_i     in   clock
//   rst_ni    in   async active-low reset
//   wait_i    in   live transfer is stalled by the routed slave this cycle
//   sel_i     in   index of the routed slave
//   clr_i     in   one-cycle clear of the sticky flag (abort has priority)
//   expire_o  out  combinational: abort must be taken at the next edge
//   flag_o    out  sticky abort flag
//   slave_o   out  slave index of the most recent abort
// ---------------------------------------------------------------------------
module ahb_s2m_wdog_cnt #(
   parameter int TO_CYC = 256
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       wait_i,
   input  logic [3:0] sel_i,
   input  logic       clr_i,
   output logic       expire_o,
   output logic       flag_o,
   output logic [3:0] slave_o
);

   localparam int TOW_RAW = $clog2(TO_CYC + 1);
   localparam int TOW     = (TOW_RAW < 1) ? 1 : TOW_RAW;
   localparam bit WD_EN   = (TO_CYC > 0);
   // Last count value before the abort; count N-1 means N stalled cycles seen.
   localparam logic [TOW-1:0] THR     = WD_EN ? TOW'(TO_CYC - 1) : '0;
   localparam logic [TOW-1:0] CNT_MAX = '1;

   logic [TOW-1:0] cnt_q;
   logic [TOW-1:0] cnt_d;
   logic           expire_s;
   logic           flag_q;
   logic [3:0]     slave_q;

   // Next-count and threshold compare; counter saturates instead of wrapping.
   always_comb begin
      cnt_d    = '0;
      expire_s = 1'b0;
      if (WD_EN && wait_i) begin
         expire_s = (cnt_q == THR);
         cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + TOW'(1'b1));
      end else begin
         expire_s = 1'b0;
         cnt_d    = '0;
      end
   end

   // Counter, sticky flag and offending-slave registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         flag_q  <= 1'b0;
         slave_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
         if (expire_s) begin
            flag_q  <= 1'b1;
            slave_q <= sel_i;
         end else if (clr_i) begin
            flag_q  <= 1'b0;
         end
      end
   end

   assign expire_o = expire_s;
   assign flag_o   = flag_q;
   assign slave_o  = slave_q;

endmodule

// File: rtl/ahb_mux_s2m_wdog.sv
// ---------------------------------------------------------------------------
// ahb_mux_s2m_wdog
//   AHB slave-to-master mux for NSLV slaves and one master. The slave select
//   is captured in the address phase and the data-phase slave's HRDATA,
//   HREADYOUT and HRESP are routed combinationally to the master. Unmapped or
//   multi-hit transfers are answered by a built-in default slave with a
//   two-cycle ERROR; a wait-state watchdog aborts a hung slave with ERROR.
// Parameters
//   NSLV    number of slaves, 2..16
//   DW      HRDATA width
//   TO_CYC  stalled cycles tolerated before abort; 0 disables the watchdog
// Ports
//   HCLK, HRESETn      clock, async active-low reset
//   HTRANS             master transfer type (address phase)
//   HSEL               one-hot decoder selects, bit i = slave i
//   HRDATA_S           slave read data, slave i at [i*DW +: DW]
//   HREADYOUT_S        slave ready outputs
//   HRESP_S            slave responses, slave i at [2i +: 2]
//   HREADY/HRESP/HRDATA muxed response to master (HREADY also to slaves)
//   to_flag            sticky watchdog-abort flag
//   to_slave           slave index of the last abort
//   to_clr             one-cycle synchronous clear of to_flag
// ---------------------------------------------------------------------------
module ahb_mux_s2m_wdog
   import ahb_mux_pkg::*;
#(
   parameter int NSLV   = 8,
   parameter int DW     = 64,
   parameter int TO_CYC = 256
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic [1:0]           HTRANS,
   input  logic [NSLV-1:0]      HSEL,
   input  logic [NSLV*DW-1:0]   HRDATA_S,
   input  logic [NSLV-1:0]      HREADYOUT_S,
   input  logic [2*NSLV-1:0]    HRESP_S,
   output logic                 HREADY,
   output logic [1:0]           HRESP,
   output logic [DW-1:0]        HRDATA,
   output logic                 to_flag,
   output logic [3:0]           to_slave,
   input  logic                 to_clr
);

   // Address-phase decode
   logic [15:0]   hsel_pad_s;
   logic [4:0]    sel_info_s;
   logic          addr_act_s;
   logic          addr_def_s;
   logic [3:0]    addr_sel_s;

   // Data-phase capture registers
   logic          dp_act_q;
   logic          dp_def_q;
   logic [3:0]    dp_sel_q;

   // Response sequencer
   mux_state_e    state_q;
   logic          rsp_err_q;
   logic          rsp_wait_q;

   // Routed slave signals and final outputs
   logic          rdy_sel_s;
   logic [1:0]    resp_sel_s;
   logic [DW-1:0] data_sel_s;
   logic          hready_s;
   logic [1:0]    hresp_s;
   logic [DW-1:0] hrdata_s;

   // Watchdog interface
   logic          wait_s;
   logic          wd_expire_s;

   // Address-phase select decode; a non-one-hot select on an active transfer
   // is steered to the default slave and the captured index is forced to 0.
   always_comb begin
      hsel_pad_s = 16'(HSEL);
      sel_info_s = onehot_idx(hsel_pad_s);
      addr_act_s = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
      addr_def_s = addr_act_s && !sel_info_s[4];
      addr_sel_s = sel_info_s[4] ? sel_info_s[3:0] : 4'd0;
   end

   // Capture the address phase whenever the bus is ready; hold otherwise.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_act_q <= 1'b0;
         dp_def_q <= 1'b0;
         dp_sel_q <= 4'd0;
      end else if (hready_s) begin
         dp_act_q <= addr_act_s;
         dp_def_q <= addr_def_s;
         dp_sel_q <= addr_sel_s;
      end
   end

   // Select the data-phase slave's ready, response and read data.
   always_comb begin
      rdy_sel_s  = 1'b0;
      resp_sel_s = 2'b00;
      data_sel_s = '0;
      for (int i = 0; i < NSLV; i++) begin
         rdy_sel_s  = rdy_sel_s  | ((dp_sel_q == 4'(i)) & HREADYOUT_S[i]);
         resp_sel_s = resp_sel_s | ((dp_sel_q == 4'(i)) ? HRESP_S[2*i +: 2] : 2'b00);
         data_sel_s = data_sel_s | ((dp_sel_q == 4'(i)) ? HRDATA_S[i*DW +: DW] : '0);
      end
   end

   // The watchdog only watches a live, routed transfer in pass-through.
   assign wait_s = (state_q == ST_PASS) && dp_act_q && !dp_def_q && !rdy_sel_s;

   ahb_s2m_wdog_cnt #(
      .TO_CYC (TO_CYC)
   ) u_wdog (
      .clk_i    (HCLK),
      .rst_ni   (HRESETn),
      .wait_i   (wait_s),
      .sel_i    (dp_sel_q),
      .clr_i    (to_clr),
      .expire_o (wd_expire_s),
      .flag_o   (to_flag),
      .slave_o  (to_slave)
   );

   // Response sequencer: pass-through, default-slave ERROR and abort ERROR.
   // An unmapped transfer jumps to DEF1 at capture so that DEF1 is its first
   // data-phase cycle; DEF2/TO2 have HREADY=1 and capture the next transfer.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= ST_PASS;
         rsp_err_q  <= 1'b0;
         rsp_wait_q <= 1'b0;
      end else begin
         case (state_q)
            ST_PASS: begin
               if (wd_expire_s) begin
                  state_q    <= ST_TO1;
                  rsp_err_q  <= 1'b1;
                  rsp_wait_q <= 1'b1;
               end else if (hready_s && addr_def_s) begin
                  state_q    <= ST_DEF1;
                  rsp_err_q  <= 1'b1;
                  rsp_wait_q <= 1'b1;
               end else begin
                  state_q    <= ST_PASS;
                  rsp_err_q  <= 1'b0;
                  rsp_wait_q <= 1'b0;
               end
            end
            ST_DEF1: begin
               state_q    <= ST_DEF2;
               rsp_err_q  <= 1'b1;
               rsp_wait_q <= 1'b0;
            end
            ST_TO1: begin
               state_q    <= ST_TO2;
               rsp_err_q  <= 1'b1;
               rsp_wait_q <= 1'b0;
            end
            ST_DEF2, ST_TO2: begin
               if (addr_def_s) begin
                  state_q    <= ST_DEF1;
                  rsp_err_q  <= 1'b1;
                  rsp_wait_q <= 1'b1;
               end else begin
                  state_q    <= ST_PASS;
                  rsp_err_q  <= 1'b0;
                  rsp_wait_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= ST_PASS;
               rsp_err_q  <= 1'b0;
               rsp_wait_q <= 1'b0;
            end
         endcase
      end
   end

   // Master-side response: sequencer ERROR, routed slave, or idle OKAY.
   always_comb begin
      hready_s = 1'b1;
      hresp_s  = HRESP_OKAY;
      hrdata_s = '0;
      if (rsp_err_q) begin
         hready_s = !rsp_wait_q;
         hresp_s  = HRESP_ERROR;
         hrdata_s = '0;
      end else if (dp_act_q && !dp_def_q) begin
         hready_s = rdy_sel_s;
         hresp_s  = resp_sel_s;
         hrdata_s = data_sel_s;
      end else begin
         hready_s = 1'b1;
         hresp_s  = HRESP_OKAY;
         hrdata_s = '0;
      end
   end

   assign HREADY = hready_s;
   assign HRESP  = hresp_s;
   assign HRDATA = hrdata_s;

endmodule

// File: tb/tb_ahb_mux_s2m_wdog.sv
// ---------------------------------------------------------------------------
// tb_ahb_mux_s2m_wdog
//   Directed bench for ahb_mux_s2m_wdog (NSLV=8, DW=64, TO_CYC=4). Expected
//   master-side responses are queued as each cycle's stimulus is driven and
//   popped and compared at the following falling edge.
// ---------------------------------------------------------------------------
module tb_ahb_mux_s2m_wdog;

   localparam int NSLV   = 8;
   localparam int DW     = 64;
   localparam int TO_CYC = 4;

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;
   localparam logic [1:0] OK       = 2'b00;
   localparam logic [1:0] ER       = 2'b01;

   logic                HCLK = 1'b0;
   logic                HRESETn;
   logic [1:0]          HTRANS;
   logic [NSLV-1:0]     HSEL;
   logic [NSLV*DW-1:0]  HRDATA_S;
   logic [NSLV-1:0]     HREADYOUT_S;
   logic [2*NSLV-1:0]   HRESP_S;
   logic                HREADY;
   logic [1:0]          HRESP;
   logic [DW-1:0]       HRDATA;
   logic                to_flag;
   logic [3:0]          to_slave;
   logic                to_clr;

   typedef struct {
      string       tag;
      logic        rdy;
      logic [1:0]  resp;
      logic [63:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   ahb_mux_s2m_wdog #(
      .NSLV   (NSLV),
      .DW     (DW),
      .TO_CYC (TO_CYC)
   ) dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .HTRANS      (HTRANS),
      .HSEL        (HSEL),
      .HRDATA_S    (HRDATA_S),
      .HREADYOUT_S (HREADYOUT_S),
      .HRESP_S     (HRESP_S),
      .HREADY      (HREADY),
      .HRESP       (HRESP),
      .HRDATA      (HRDATA),
      .to_flag     (to_flag),
      .to_slave    (to_slave),
      .to_clr      (to_clr)
   );

   always #5 HCLK = ~HCLK;

   function automatic logic [63:0] pat(input int i);
      return {32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i)};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic push(input string tag, input logic rdy, input logic [1:0] resp,
                       input logic [63:0] data);
      exp_t e;
      e.tag  = tag;
      e.rdy  = rdy;
      e.resp = resp;
      e.data = data;
      sb_q.push_back(e);
   endtask

   task automatic sample();
      exp_t e;
      @(negedge HCLK);
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL sb_empty: observed no entry expected one");
      end else begin
         e = sb_q.pop_front();
         check({e.tag, "_rdy"},  64'(HREADY), 64'(e.rdy));
         check({e.tag, "_resp"}, 64'(HRESP),  64'(e.resp));
         check({e.tag, "_data"}, HRDATA,      e.data);
      end
   endtask

   task automatic cyc(input string tag, input logic rdy, input logic [1:0] resp,
                      input logic [63:0] data);
      push(tag, rdy, resp, data);
      sample();
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   initial begin
      HRESETn     = 1'b0;
      HTRANS      = T_IDLE;
      HSEL        = '0;
      to_clr      = 1'b0;
      HREADYOUT_S = '1;
      HRESP_S     = '0;
      for (int i = 0; i < NSLV; i++) HRDATA_S[i*DW +: DW] = pat(i);

      // Reset values
      cyc("rst", 1'b1, OK, 64'd0);
      check("rst_flag",  64'(to_flag),  64'd0);
      check("rst_slave", 64'(to_slave), 64'd0);
      tick(); HRESETn = 1'b1;
      cyc("rel_idle", 1'b1, OK, 64'd0);

      // 1: slave 3 with two wait states
      tick(); HTRANS = T_NONSEQ; HSEL = 8'h08;
      cyc("t1_addr", 1'b1, OK, 64'd0);
      tick(); HTRANS = T_IDLE; HSEL = 8'h00; HREADYOUT_S[3] = 1'b0; HRDATA_S[3*DW +: DW] = 64'd0;
      cyc("t1_w1", 1'b0, OK, 64'd0);
      tick();
      cyc("t1_w2", 1'b0, OK, 64'd0);
      tick(); HREADYOUT_S[3] = 1'b1; HRDATA_S[3*DW +: DW] = 64'hDEAD_BEEF_0123_4567;
      cyc("t1_data", 1'b1, OK, 64'hDEAD_BEEF_0123_4567);
      tick(); HRDATA_S[3*DW +: DW] = pat(3);
      cyc("t1_idle", 1'b1, OK, 64'd0);

      // 2: unmapped then multi-hit, back to back
      tick(); HTRANS = T_NONSEQ; HSEL = 8'h00;
      cyc("t2a_addr", 1'b1, OK, 64'd0);
      tick(); HSEL = 8'h06;
      cyc("t2a_def1", 1'b0, ER, 64'd0);
      tick();
      cyc("t2a_def2", 1'b1, ER, 64'd0);
      tick(); HTRANS = T_IDLE; HSEL = 8'h00;
      cyc("t2b_def1", 1'b0, ER, 64'd0);
      tick();
      cyc("t2b_def2", 1'b1, ER, 64'd0);
      tick();
      cyc("t2_idle", 1'b1, OK, 64'd0);

      // 3: slave 5 hangs -> exactly 4 wait cycles, then abort
      tick(); HTRANS = T_NONSEQ; HSEL = 8'h20;
      cyc("t3_addr", 1'b1, OK, 64'd0);
      tick(); HTRANS = T_IDLE; HSEL = 8'h00; HREADYOUT_S[5] = 1'b0;
      cyc("t3_w1", 1'b0, OK, pat(5));
      for (int k = 2; k <= TO_CYC; k++) begin
         tick();
         cyc($sformatf("t3_w%0d", k), 1'b0, OK, pat(5));
      end
      tick();
      cyc("t3_to1", 1'b0, ER, 64'd0);
      check("t3_flag",  64'(to_flag),  64'd1);
      check("t3_slave", 64'(to_slave), 64'd5);
      tick();
      cyc("t3_to2", 1'b1, ER, 64'd0);
      tick();
      cyc("t3_idle", 1'b1, OK, 64'd0);
      check("t3_flag_hold", 64'(to_flag), 64'd1);
      tick(); HREADYOUT_S[5] = 1'b1; to_clr = 1'b1;
      cyc("t3_clr", 1'b1, OK, 64'd0);
      tick(); to_clr = 1'b0;
      cyc("t3_after_clr", 1'b1, OK, 64'd0);
      check("t3_flag_clr", 64'(to_flag), 64'd0);

      // 4a: slave 2 answers on the threshold cycle -> normal completion
      tick(); HTRANS = T_NONSEQ; HSEL = 8'h04;
      cyc("t4a_addr", 1'b1, OK, 64'd0);
      tick(); HTRANS = T_IDLE; HSEL = 8'h00; HREADYOUT_S[2] = 1'b0;
      cyc("t4a_w1", 1'b0, OK, pat(2));
      tick();
      cyc("t4a_w2", 1'b0, OK, pat(2));
      tick();
      cyc("t4a_w3", 1'b0, OK, pat(2));
      tick(); HREADYOUT_S[2] = 1'b1;
      cyc("t4a_done", 1'b1, OK, pat(2));
      tick();
      cyc("t4a_idle", 1'b1, OK, 64'd0);
      check("t4a_flag", 64'(to_flag), 64'd0);

      // 4b: abort with to_clr in the same cycle -> abort wins
      tick(); HTRANS = T_NONSEQ; HSEL = 8'h04;
      cyc("t4b_addr", 1'b1, OK, 64'd0);
      tick(); HTRANS = T_IDLE; HSEL = 8'h00; HREADYOUT_S[2] = 1'b0;
      cyc("t4b_w1", 1'b0, OK, pat(2));
      tick();
      cyc("t4b_w2", 1'b0, OK, pat(2));
      tick();
      cyc("t4b_w3", 1'b0, OK, pat(2));
      tick(); to_clr = 1'b1;
      cyc("t4b_w4", 1'b0, OK, pat(2));
      tick(); to_clr = 1'b0;
      cyc("t4b_to1", 1'b0, ER, 64'd0);
      check("t4b_flag",  64'(to_flag),  64'd1);
      check("t4b_slave", 64'(to_slave), 64'd2);
      tick();
      cyc("t4b_to2", 1'b1, ER, 64'd0);
      tick(); HREADYOUT_S[2] = 1'b1;
      cyc("t4b_idle", 1'b1, OK, 64'd0);

      // 5: reset in the middle of a wait on slave 1
      tick(); HTRANS = T_NONSEQ; HSEL = 8'h02;
      cyc("t5_addr", 1'b1, OK, 64'd0);
      tick(); HTRANS = T_IDLE; HSEL = 8'h00; HREADYOUT_S[1] = 1'b0;
      cyc("t5_w1", 1'b0, OK, pat(1));
      tick(); HRESETn = 1'b0;
      cyc("t5_rst", 1'b1, OK, 64'd0);
      check("t5_flag",  64'(to_flag),  64'd0);
      check("t5_slave", 64'(to_slave), 64'd0);
      tick(); HRESETn = 1'b1;
      cyc("t5_rel", 1'b1, OK, 64'd0);
      tick();
      cyc("t5_idle", 1'b1, OK, 64'd0);

      // 6: back-to-back SEQ to slaves 0, 7, 0
      tick(); HREADYOUT_S[1] = 1'b1; HTRANS = T_SEQ; HSEL = 8'h01;
      cyc("t6_addr", 1'b1, OK, 64'd0);
      tick(); HSEL = 8'h80;
      cyc("t6_s0", 1'b1, OK, pat(0));
      tick(); HSEL = 8'h01;
      cyc("t6_s7", 1'b1, OK, pat(7));
      tick(); HTRANS = T_IDLE; HSEL = 8'h00;
      cyc("t6_s0b", 1'b1, OK, pat(0));
      tick();
      cyc("t6_idle", 1'b1, OK, 64'd0);

      // 7: slave-issued two-cycle ERROR passes through unaltered
      tick(); HTRANS = T_NONSEQ; HSEL = 8'h40;
      cyc("t7_addr", 1'b1, OK, 64'd0);
      tick(); HTRANS = T_IDLE; HSEL = 8'h00; HREADYOUT_S[6] = 1'b0; HRESP_S[13:12] = ER;
      cyc("t7_err1", 1'b0, ER, pat(6));
      tick(); HREADYOUT_S[6] = 1'b1;
      cyc("t7_err2", 1'b1, ER, pat(6));
      tick(); HRESP_S[13:12] = OK;
      cyc("t7_idle", 1'b1, OK, 64'd0);
      check("t7_flag", 64'(to_flag), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
